dsp_mac_seq: RTL and testbench

//  Upstream sequencer for the DSP_sync (DSP48A1) slice. Accepts a valid/ready stream of 18-bit operand pairs and drives
//  the slice's A/B/D/C/OPMODE/CE/RST ports to run N_TAPS-long multiply-accumulate frames, one per frame.

---
 rtl/dsp_pkg.sv | 25 ++
 rtl/dsp_rst_stretch.sv | 28 ++
 rtl/dsp_mac_seq.sv | 141 ++++++++++++++
 tb/tb_dsp_mac_seq.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP48A1 MAC sequencer: operand/accumulator widths,
// OPMODE encodings and FSM state encoding.
package dsp_pkg;

    localparam int A_W  = 18;
    localparam int P_W  = 48;
    localparam int OP_W = 8;

    // X=M, Z=0 starts a frame; X=M, Z=P accumulates; X=0, Z=P holds P.
    localparam logic [OP_W-1:0] OPM_FIRST = 8'h01;
    localparam logic [OP_W-1:0] OPM_ACC   = 8'h09;
    localparam logic [OP_W-1:0] OPM_HOLD  = 8'h08;
    localparam int              OPM_PREADD_BIT = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

    function automatic logic [OP_W-1:0] tap_opmode(input logic first, input logic preadd);
        logic [OP_W-1:0] op;
        op = first ? OPM_FIRST : OPM_ACC;
        op[OPM_PREADD_BIT] = preadd;
        return op;
    endfunction

endpackage

// File: rtl/dsp_rst_stretch.sv
// dsp_rst_stretch: asserts the slice reset asynchronously with rst_n and
// releases it synchronously RST_HOLD cycles after rst_n deasserts.
module dsp_rst_stretch #(
    parameter int RST_HOLD = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic dsp_rst
);

    localparam int CNT_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= CNT_W'(RST_HOLD);
            dsp_rst  <= 1'b1;
        end else begin
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - CNT_W'(1);
            end
            // Registered so the slice reset drops exactly when the count expires.
            dsp_rst <= (hold_cnt > CNT_W'(1));
        end
    end

endmodule

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: valid/ready front end that runs N_TAPS-long MAC frames on a DSP48A1
// slice and returns each frame sum on a one-entry result port. Pre-adder: DSP_MAC_PREADD_EN.
//
//  state    | meaning
//  ST_IDLE  | waiting for the first tap of a frame (tap_cnt == 0)
//  ST_ACC   | mid-frame, accumulating products onto P
module dsp_mac_seq
    import dsp_pkg::*;
#(
    parameter int N_TAPS   = 8,
    parameter int PIPE_LAT = 3,
    parameter int RST_HOLD = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [A_W-1:0]  s_a,
    input  logic [A_W-1:0]  s_b,
    input  logic [A_W-1:0]  s_d,
    output logic [A_W-1:0]  dsp_a,
    output logic [A_W-1:0]  dsp_b,
    output logic [A_W-1:0]  dsp_d,
    output logic [P_W-1:0]  dsp_c,
    output logic [OP_W-1:0] dsp_opmode,
    output logic            dsp_carryin,
    output logic            dsp_ce,
    output logic            dsp_rst,
    input  logic [P_W-1:0]  dsp_p,
    output logic            r_valid,
    input  logic            r_ready,
    output logic [P_W-1:0]  r_data
);

    localparam int              TAP_W    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

`ifdef DSP_MAC_PREADD_EN
    localparam logic PREADD = 1'b1;
`else
    localparam logic PREADD = 1'b0;
    logic unused_s_d;
    assign unused_s_d = ^s_d;
`endif

    logic [0:0]       state;
    logic [TAP_W-1:0] tap_cnt;
    logic [PIPE_LAT:0] mk_pipe;
    logic             snap_vld;
    logic [P_W-1:0]   p_snap;
    logic             last_tap;
    logic             in_flight;
    logic             accept;

    dsp_rst_stretch #(
        .RST_HOLD (RST_HOLD)
    ) u_rst_stretch (
        .clk     (clk),
        .rst_n   (rst_n),
        .dsp_rst (dsp_rst)
    );

    assign dsp_c       = '0;
    assign dsp_carryin = 1'b0;

    assign last_tap  = (tap_cnt == LAST_TAP);
    assign in_flight = (|mk_pipe) || snap_vld;

    // The last tap waits until the result slot and the marker pipe are both empty,
    // so every capture lands in an empty slot.
    assign s_ready = !dsp_rst && !(last_tap && (r_valid || in_flight));
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tap_cnt <= '0;
        end else if (accept) begin
            if (last_tap) begin
                state   <= ST_IDLE;
                tap_cnt <= '0;
            end else begin
                state   <= ST_ACC;
                tap_cnt <= tap_cnt + TAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_d      <= '0;
            dsp_opmode <= OPM_HOLD;
            dsp_ce     <= 1'b0;
        end else begin
            dsp_ce <= 1'b1;
            if (accept) begin
                dsp_a      <= s_a;
                dsp_b      <= s_b;
`ifdef DSP_MAC_PREADD_EN
                dsp_d      <= s_d;
`else
                dsp_d      <= '0;
`endif
                dsp_opmode <= tap_opmode(state == ST_IDLE, PREADD);
            end else begin
                dsp_opmode <= OPM_HOLD;
            end
        end
    end

    // Marker reaches the top stage once the last product has settled in P;
    // P is snapshotted on the next edge and presented one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mk_pipe  <= '0;
            snap_vld <= 1'b0;
            p_snap   <= '0;
        end else begin
            mk_pipe  <= {mk_pipe[PIPE_LAT-1:0], accept && last_tap};
            snap_vld <= mk_pipe[PIPE_LAT];
            if (mk_pipe[PIPE_LAT]) begin
                p_snap <= dsp_p;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (snap_vld) begin
            r_valid <= 1'b1;
            r_data  <= p_snap;
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: drives dsp_mac_seq against a behavioural DSP48A1 slice and checks
// frame results, OPMODE sequencing, flow control and reset behaviour.
module tb_dsp_mac_seq;
    import dsp_pkg::*;

    localparam int N_TAPS   = 4;
    localparam int PIPE_LAT = 3;
    localparam int RST_HOLD = 2;
    localparam int LAT      = PIPE_LAT + 2;
`ifdef DSP_MAC_PREADD_EN
    localparam bit PREADD_EN = 1'b1;
`else
    localparam bit PREADD_EN = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [A_W-1:0]  s_a, s_b, s_d;
    logic [A_W-1:0]  dsp_a, dsp_b, dsp_d;
    logic [P_W-1:0]  dsp_c;
    logic [OP_W-1:0] dsp_opmode;
    logic            dsp_carryin, dsp_ce, dsp_rst;
    logic [P_W-1:0]  dsp_p = '0;
    logic            r_valid, r_ready;
    logic [P_W-1:0]  r_data;

    dsp_mac_seq #(
        .N_TAPS   (N_TAPS),
        .PIPE_LAT (PIPE_LAT),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_a         (s_a),
        .s_b         (s_b),
        .s_d         (s_d),
        .dsp_a       (dsp_a),
        .dsp_b       (dsp_b),
        .dsp_d       (dsp_d),
        .dsp_c       (dsp_c),
        .dsp_opmode  (dsp_opmode),
        .dsp_carryin (dsp_carryin),
        .dsp_ce      (dsp_ce),
        .dsp_rst     (dsp_rst),
        .dsp_p       (dsp_p),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DSP48A1 slice, default registers: A1/B1/D/OPMODE -> M -> P.
    logic signed [17:0] sl_a1 = '0, sl_b1 = '0, sl_d1 = '0;
    logic        [7:0]  sl_op1 = '0, sl_op2 = '0;
    logic signed [47:0] sl_m = '0;
    logic signed [17:0] sl_bpre;
    logic        [47:0] sl_x, sl_z;

    assign sl_bpre = sl_op1[4] ? (sl_b1 + sl_d1) : sl_b1;
    assign sl_x    = (sl_op2[1:0] == 2'b01) ? sl_m  : '0;
    assign sl_z    = (sl_op2[3:2] == 2'b10) ? dsp_p : '0;

    always @(posedge clk) begin
        if (dsp_rst) begin
            sl_a1 <= '0; sl_b1 <= '0; sl_d1 <= '0;
            sl_op1 <= '0; sl_op2 <= '0; sl_m <= '0; dsp_p <= '0;
        end else if (dsp_ce) begin
            sl_a1  <= dsp_a;
            sl_b1  <= dsp_b;
            sl_d1  <= dsp_d;
            sl_op1 <= dsp_opmode;
            sl_m   <= sl_a1 * sl_bpre;
            sl_op2 <= sl_op1;
            dsp_p  <= sl_x + sl_z;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] prod(input logic [17:0] a, input logic [17:0] b,
                                         input logic [17:0] d);
        logic signed [17:0] bb;
        logic signed [47:0] r;
        bb = PREADD_EN ? (b + d) : b;
        r  = $signed(a) * bb;
        return r;
    endfunction

    // Reference model: frame sums from accepted samples, result due LAT edges after the last tap.
    typedef struct {
        int          due;
        logic [47:0] sum;
    } res_t;

    res_t        pend[$];
    int          cyc = 0;
    int          m_taps = 0;
    logic [47:0] m_sum = '0;
    logic        slot_v = 1'b0;
    logic [47:0] slot_d = '0;
    logic [3:0]  acc_hist = '0;
    logic [47:0] p_prev = '0;
    logic        prev_dsprst = 1'b1;
    logic [7:0]  exp_op;

    logic        acc_q = 1'b0, rel_q = 1'b0;
    logic [17:0] a_q = '0, b_q = '0, d_q = '0;

    always @(posedge clk) begin
        acc_q <= s_valid && s_ready;
        rel_q <= r_valid && r_ready;
        a_q   <= s_a;
        b_q   <= s_b;
        d_q   <= s_d;
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend.delete();
            m_taps   = 0;
            m_sum    = '0;
            slot_v   = 1'b0;
            acc_hist = '0;
            chk("rst_r_valid", 64'(r_valid), 64'd0);
            chk("rst_r_data",  64'(r_data), 64'd0);
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_dsp_rst", 64'(dsp_rst), 64'd1);
            chk("rst_dsp_ce",  64'(dsp_ce), 64'd0);
            chk("rst_opmode",  64'(dsp_opmode), 64'h08);
        end else begin
            if (rel_q) slot_v = 1'b0;
            exp_op = OPM_HOLD;
            if (acc_q) begin
                exp_op = (m_taps == 0) ? OPM_FIRST : OPM_ACC;
                exp_op[OPM_PREADD_BIT] = PREADD_EN;
                m_sum = m_sum + prod(a_q, b_q, d_q);
                m_taps++;
                if (m_taps == N_TAPS) begin
                    pend.push_back('{due: cyc + LAT, sum: m_sum});
                    m_taps = 0;
                    m_sum  = '0;
                end
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                slot_v = 1'b1;
                slot_d = pend[0].sum;
                void'(pend.pop_front());
            end
            chk("r_valid", 64'(r_valid), 64'(slot_v));
            if (slot_v) chk("r_data", 64'(r_data), 64'(slot_d));
            chk("opmode", 64'(dsp_opmode), 64'(exp_op));
            acc_hist = {acc_hist[2:0], acc_q};
            if (!prev_dsprst && !acc_hist[3]) chk("p_hold", 64'(dsp_p), 64'(p_prev));
        end
        p_prev      = dsp_p;
        prev_dsprst = dsp_rst;
    end

    task automatic wait_accept(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!s_ready && n < 100);
        chk({name, "_accept"}, 64'(s_ready), 64'd1);
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        s_d = d;
        wait_accept("send");
    endtask

    task automatic bubble(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic wait_result(input string name, input logic [47:0] exp);
        int n;
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
        while (!r_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, 64'(r_valid), 64'd1);
        chk({name, "_lat"}, 64'(n), 64'(LAT));
        chk({name, "_data"}, 64'(r_data), 64'(exp));
    endtask

    logic stall_seen;

    initial begin
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_a = '0; s_b = '0; s_d = '0;
        r_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("init_dsp_a", 64'(dsp_a), 64'd0);
        chk("init_dsp_c", 64'(dsp_c), 64'd0);
        chk("init_carryin", 64'(dsp_carryin), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_hold1", 64'(dsp_rst), 64'd1);
        chk("rel_ce", 64'(dsp_ce), 64'd1);
        chk("rel_ready1", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("rel_hold2", 64'(dsp_rst), 64'd0);
        chk("rel_ready2", 64'(s_ready), 64'd1);

        // back-to-back frame: 2+12+30+56 = 100
        send(18'd1, 18'd2, 18'd0);
        send(18'd3, 18'd4, 18'd0);
        send(18'd5, 18'd6, 18'd0);
        send(18'd7, 18'd8, 18'd0);
        wait_result("b2b", 48'h64);
        bubble(3);

        // same frame with bubbles between samples
        send(18'd1, 18'd2, 18'd0);
        bubble(1);
        send(18'd3, 18'd4, 18'd0);
        bubble(3);
        send(18'd5, 18'd6, 18'd0);
        bubble(2);
        send(18'd7, 18'd8, 18'd0);
        wait_result("bub", 48'h64);
        bubble(2);

        // signed: -2 -12 -30 +56 = 12
        send(-18'sd1, 18'sd2, 18'd0);
        send(-18'sd3, 18'sd4, 18'd0);
        send(18'sd5, -18'sd6, 18'd0);
        send(18'sd7, 18'sd8, 18'd0);
        wait_result("sgn", 48'hC);
        bubble(2);

        // backpressure: frame 1 held unread, frame 2 stalls at its last tap
        @(negedge clk);
        r_ready = 1'b0;
        send(18'd1, 18'd2, 18'd0);
        send(18'd3, 18'd4, 18'd0);
        send(18'd5, 18'd6, 18'd0);
        send(18'd7, 18'd8, 18'd0);
        send(18'd1, 18'd1, 18'd0);
        send(18'd1, 18'd1, 18'd0);
        send(18'd1, 18'd1, 18'd0);
        @(negedge clk);
        s_valid = 1'b1;
        s_a = 18'd1; s_b = 18'd1; s_d = 18'd0;
        stall_seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            stall_seen = stall_seen | s_ready;
        end
        @(negedge clk);
        chk("bp_stall", 64'(stall_seen), 64'd0);
        chk("bp_held_valid", 64'(r_valid), 64'd1);
        chk("bp_held_data", 64'(r_data), 64'h64);
        r_ready = 1'b1;
        wait_accept("bp");
        wait_result("bp2", 48'd4);
        bubble(2);

        // reset mid-frame
        send(18'd9, 18'd9, 18'd0);
        send(18'd9, 18'd9, 18'd0);
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(r_valid), 64'd0);
        chk("mid_rst_dsprst", 64'(dsp_rst), 64'd1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_hold1", 64'(dsp_rst), 64'd1);
        chk("mid_ready1", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("mid_hold2", 64'(dsp_rst), 64'd0);
        chk("mid_valid", 64'(r_valid), 64'd0);
        send(18'd2, 18'd2, 18'd0);
        send(18'd2, 18'd2, 18'd0);
        send(18'd2, 18'd2, 18'd0);
        send(18'd2, 18'd2, 18'd0);
        wait_result("mid", 48'd16);
        bubble(2);

        // pre-adder frame: 2*(3+1)*4 with the feature, 2*1*4 without
        send(18'd2, 18'd1, 18'd3);
        send(18'd2, 18'd1, 18'd3);
        send(18'd2, 18'd1, 18'd3);
        send(18'd2, 18'd1, 18'd3);
`ifdef DSP_MAC_PREADD_EN
        wait_result("pre", 48'd32);
`else
        wait_result("pre", 48'd8);
`endif
        bubble(6);
        chk("end_carryin", 64'(dsp_carryin), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
